// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch FSM states, fetch buffer entry and PC step.
package rv32i_types;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_PC_STEP = 32'd4;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_unit_buffer.sv
// Small FIFO of fetched {pc, instr} entries; flush clears it, head reads 0 when empty.
module fetch_buffer
    import rv32i_types::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty
);
    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem reads into a small buffer feeding decode.
// Optional FETCH_PERF_EN adds saturating fetched/squashed counters.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_rdata,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);
    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d, req_addr_q, req_addr_d, redir_pc;
    logic             push, pop, full, empty;
    logic [CNT_W-1:0] count, count_after;
    fetch_entry_t     head, push_entry;

    assign redir_pc    = redirect_pc & ~32'd3;
    assign instr_valid = !empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign push        = (state_q == FETCH) && imem_resp && !redirect_valid;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign push_entry  = '{pc: req_addr_q, instr: imem_rdata};
    assign instr_rdata = head.instr;
    assign instr_pc    = head.pc;

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk(clk), .rst_n(rst), .push(push), .push_data(push_entry), .pop(pop),
        .flush(redirect_valid), .head(head), .count(count), .full(full), .empty(empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // In FETCH pc always equals req_addr, so the next sequential address is req_addr+4.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (redirect_valid) pc_d = redir_pc;
        case (state_q)
            IDLE: begin
                state_d    = FETCH;
                req_addr_d = redirect_valid ? redir_pc : pc_q;
            end
            FETCH: begin
                if (redirect_valid) begin
                    if (imem_resp) req_addr_d = redir_pc;
                    else           state_d    = DRAIN;
                end else if (imem_resp) begin
                    pc_d = req_addr_q + FETCH_PC_STEP;
                    if (count_after < DEPTH_C) req_addr_d = req_addr_q + FETCH_PC_STEP;
                    else                       state_d    = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    state_d    = FETCH;
                    req_addr_d = redir_pc;
                end else if (count_after < DEPTH_C) begin
                    state_d    = FETCH;
                    req_addr_d = pc_q;
                end
            end
            DRAIN: begin
                // The stale address stays on the bus until its response retires.
                if (imem_resp) begin
                    state_d    = FETCH;
                    req_addr_d = redirect_valid ? redir_pc : pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_read    = (state_q == FETCH) || (state_q == DRAIN);
        imem_address = req_addr_q;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

`ifdef FETCH_PERF_EN
    logic        squash_resp;
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_squashed_q, perf_squashed_d;

    always_comb begin
        squash_resp     = imem_resp && (((state_q == FETCH) && redirect_valid) || (state_q == DRAIN));
        perf_fetched_d  = sat_add32(perf_fetched_q, {31'd0, push});
        perf_squashed_d = sat_add32(perf_squashed_q,
                                    {31'd0, squash_resp} + (redirect_valid ? 32'(count) : 32'd0));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap, reset mid-drain.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_read, imem_resp, redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_address, imem_rdata, redirect_pc, instr_rdata, instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_squashed;
`endif

    // Memory model: data = address ^ 32'hC0DE0000, response mem_lat cycles after request.
    logic        mem_en = 1'b1;
    int          mem_lat = 0;
    logic        mdl_resp = 1'b0, man_resp = 1'b0;
    logic [31:0] mdl_rdata = '0, man_rdata = '0;
    logic        pend = 1'b0;
    int          lat_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;

    assign imem_resp  = mem_en ? mdl_resp  : man_resp;
    assign imem_rdata = mem_en ? mdl_rdata : man_rdata;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_read(imem_read), .imem_address(imem_address),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_rdata(instr_rdata), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            mdl_resp = 1'b0;
            pend     = 1'b0;
        end else begin
            if (mdl_resp) begin
                mdl_resp = 1'b0;
                pend     = 1'b0;
            end
            if (imem_read && !pend) begin
                pend    = 1'b1;
                lat_cnt = mem_lat;
            end
            if (pend) begin
                if (lat_cnt == 0) begin
                    mdl_resp  = 1'b1;
                    mdl_rdata = imem_address ^ 32'hC0DE_0000;
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Leaves the caller in the IDLE cycle right after reset release.
    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;

        // Reset values
        smp();
        chk("rst_read",  {31'd0, imem_read},   32'd0);
        chk("rst_addr",  imem_address,         32'h0000_0060);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_rdata", instr_rdata,          32'd0);
        chk("rst_pc",    instr_pc,             32'd0);
`ifdef FETCH_PERF_EN
        chk("rst_pf_fetch", perf_fetched,  32'd0);
        chk("rst_pf_squash", perf_squashed, 32'd0);
`endif

        // Streaming with 1-cycle memory and decode always ready
        do_reset();
        smp(); chk("idle_read", {31'd0, imem_read}, 32'd0);
        nxt(); smp();
        chk("first_read", {31'd0, imem_read}, 32'd1);
        chk("first_addr", imem_address, 32'h0000_0060);
        nxt(); smp();
        chk("s0_valid", {31'd0, instr_valid}, 32'd1);
        chk("s0_pc",    instr_pc,    32'h0000_0060);
        chk("s0_rdata", instr_rdata, 32'hC0DE_0060);
        nxt(); smp();
        chk("s1_pc",    instr_pc,    32'h0000_0064);
        chk("s1_rdata", instr_rdata, 32'hC0DE_0064);
        nxt(); smp();
        chk("s2_pc",    instr_pc,    32'h0000_0068);

        // Backpressure: buffer fills to DEPTH, then one pop restarts fetch
        instr_ready = 1'b0;
        do_reset();
        nxt(); nxt(); nxt(); smp();
        chk("bp_wait_read", {31'd0, imem_read}, 32'd0);
        chk("bp_valid",     {31'd0, instr_valid}, 32'd1);
        chk("bp_head_pc",   instr_pc, 32'h0000_0060);
        nxt(); smp();
        chk("bp_hold_read", {31'd0, imem_read}, 32'd0);
        nxt(); instr_ready = 1'b1; smp();
        chk("bp_pop_pc",    instr_pc, 32'h0000_0060);
        nxt(); instr_ready = 1'b0; smp();
        chk("bp_refetch",   {31'd0, imem_read}, 32'd1);
        chk("bp_ref_addr",  imem_address, 32'h0000_0068);
        chk("bp_next_pc",   instr_pc, 32'h0000_0064);

        // Redirect while a 3-cycle read of 0x64 is pending
        instr_ready = 1'b1;
        mem_lat     = 2;
        do_reset();
        nxt(); nxt(); nxt(); nxt(); smp();
        chk("rd_pre_pc", instr_pc, 32'h0000_0060);
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; smp();
        chk("rd_addr_hold", imem_address, 32'h0000_0064);
        chk("rd_valid_mask", {31'd0, instr_valid}, 32'd0);
        nxt(); redirect_valid = 1'b0; smp();
        chk("rd_drain_read", {31'd0, imem_read}, 32'd1);
        chk("rd_drain_addr", imem_address, 32'h0000_0064);
        chk("rd_drain_valid", {31'd0, instr_valid}, 32'd0);
        nxt(); smp();
        chk("rd_new_addr", imem_address, 32'h0000_0200);
        for (int i = 0; i < 10 && !instr_valid; i++) begin
            nxt(); smp();
        end
        chk("rd_wait_valid", {31'd0, instr_valid}, 32'd1);
        chk("rd_first_pc",   instr_pc,    32'h0000_0200);
        chk("rd_first_data", instr_rdata, 32'hC0DE_0200);

        // Redirect coinciding with a response and a ready decoder
        mem_lat = 0;
        do_reset();
        nxt(); nxt(); smp();
        chk("rr_nonempty", {31'd0, instr_valid}, 32'd1);
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; smp();
        chk("rr_mask", {31'd0, instr_valid}, 32'd0);
        nxt(); redirect_valid = 1'b0; smp();
        chk("rr_empty", {31'd0, instr_valid}, 32'd0);
        chk("rr_read",  {31'd0, imem_read}, 32'd1);
        chk("rr_addr",  imem_address, 32'h0000_0400);
`ifdef FETCH_PERF_EN
        chk("rr_pf_fetch",  perf_fetched,  32'd2);
        chk("rr_pf_squash", perf_squashed, 32'd2);
`endif
        nxt(); smp();
        chk("rr_pc", instr_pc, 32'h0000_0400);

        // Redirect to the top word: next sequential fetch wraps to 0
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        nxt(); redirect_valid = 1'b0; smp();
        chk("wr_addr_top", imem_address, 32'hFFFF_FFFC);
        nxt(); smp();
        chk("wr_addr_zero", imem_address, 32'h0000_0000);
        chk("wr_pc_top",    instr_pc,     32'hFFFF_FFFC);
        chk("wr_data_top",  instr_rdata,  32'h3F21_FFFC);
        nxt(); smp();
        chk("wr_pc_zero",   instr_pc,     32'h0000_0000);

        // Reset during DRAIN, then a stale response arrives while IDLE
        mem_en   = 1'b0;
        man_resp = 1'b0;
        do_reset();
        nxt(); smp();
        chk("md_read", {31'd0, imem_read}, 32'd1);
        nxt(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        nxt(); redirect_valid = 1'b0; smp();
        chk("md_drain_addr", imem_address, 32'h0000_0060);
        nxt(); rst = 1'b0; smp();
        chk("md_rst_read", {31'd0, imem_read}, 32'd0);
        chk("md_rst_addr", imem_address, 32'h0000_0060);
`ifdef FETCH_PERF_EN
        chk("md_pf_fetch",  perf_fetched,  32'd0);
        chk("md_pf_squash", perf_squashed, 32'd0);
`endif
        nxt(); rst = 1'b1; man_resp = 1'b1; man_rdata = 32'hDEAD_BEEF; smp();
        chk("md_idle_read", {31'd0, imem_read}, 32'd0);
        nxt(); man_resp = 1'b0; smp();
        chk("md_restart_addr", imem_address, 32'h0000_0060);
        chk("md_no_stale", {31'd0, instr_valid}, 32'd0);
        nxt(); man_resp = 1'b1; man_rdata = 32'h1234_5678; smp();
        chk("md_still_empty", {31'd0, instr_valid}, 32'd0);
        nxt(); man_resp = 1'b0; smp();
        chk("md_valid", {31'd0, instr_valid}, 32'd1);
        chk("md_pc",    instr_pc,    32'h0000_0060);
        chk("md_data",  instr_rdata, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
